// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes source/dest registers, tracks pending writes in a
// scoreboard, stalls on RAW hazards. Define OPERAND_FETCH_BYPASS_EN to forward writeback data.
module operand_fetch #(
  parameter int  DATA_WIDTH   = 32,
  parameter int  NUM_REGISTER = 32,
  localparam int AddrWidth    = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  input  logic [31:0]           instr_i,
  input  logic [31:0]           pc_i,
  output logic                  instr_ready_o,
  output logic [AddrWidth-1:0]  rs1_addr_o,
  output logic [AddrWidth-1:0]  rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic                  wb_valid_i,
  input  logic [AddrWidth-1:0]  wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [31:0]           ex_pc_o,
  output logic [31:0]           ex_instr_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_o,
  output logic [AddrWidth-1:0]  ex_rd_addr_o,
  output logic                  ex_rd_we_o,
  input  logic                  flush_i
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic                    ex_valid_q, ex_valid_d;
  logic [31:0]             ex_pc_q, ex_pc_d;
  logic [31:0]             ex_instr_q, ex_instr_d;
  logic [DATA_WIDTH-1:0]   ex_rs1_q, ex_rs1_d;
  logic [DATA_WIDTH-1:0]   ex_rs2_q, ex_rs2_d;
  logic [AddrWidth-1:0]    ex_rd_q, ex_rd_d;
  logic                    ex_we_q, ex_we_d;
  logic [NUM_REGISTER-1:0] pending_q, pending_d;

  logic [6:0]            opcode;
  logic [AddrWidth-1:0]  rs1, rs2, rd;
  logic                  uses_rs1, uses_rs2, writes_rd;
  logic                  src1_live, src2_live;
  logic                  fwd1, fwd2;
  logic                  hazard, accept;
  logic [DATA_WIDTH-1:0] op1, op2;

  assign opcode     = instr_i[6:0];
  assign rs1        = instr_i[15 +: AddrWidth];
  assign rs2        = instr_i[20 +: AddrWidth];
  assign rd         = instr_i[7 +: AddrWidth];
  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OpLui, OpAuipc, OpJal: uses_rs1 = 1'b0;
      default:               uses_rs1 = 1'b1;
    endcase
    case (opcode)
      OpBranch, OpStore, OpOp: uses_rs2 = 1'b1;
      default:                 uses_rs2 = 1'b0;
    endcase
    case (opcode)
      OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpOpImm, OpOp, OpSystem:
        writes_rd = (rd != '0);
      default:
        writes_rd = 1'b0;
    endcase
  end

  assign src1_live = uses_rs1 && (rs1 != '0);
  assign src2_live = uses_rs2 && (rs2 != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
  assign fwd1 = wb_valid_i && (wb_addr_i == rs1) && (rs1 != '0);
  assign fwd2 = wb_valid_i && (wb_addr_i == rs2) && (rs2 != '0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Hazard is qualified by instr_valid_i so an idle bus never affects readiness.
  assign hazard = instr_valid_i &&
                  ((src1_live && pending_q[rs1] && !fwd1) ||
                   (src2_live && pending_q[rs2] && !fwd2));

  assign instr_ready_o = !hazard && !flush_i && (!ex_valid_q || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  assign op1 = src1_live ? (fwd1 ? wb_data_i : rs1_data_i) : '0;
  assign op2 = src2_live ? (fwd2 ? wb_data_i : rs2_data_i) : '0;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_instr_d = ex_instr_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = pc_i;
      ex_instr_d = instr_i;
      ex_rs1_d   = op1;
      ex_rs2_d   = op2;
      ex_rd_d    = rd;
      ex_we_d    = writes_rd;
    end else if (ex_valid_q && ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  // Clears apply first so a same-edge set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i && (wb_addr_i != '0))
      pending_d[wb_addr_i] = 1'b0;
    if (flush_i && ex_valid_q && ex_we_q)
      pending_d[ex_rd_q] = 1'b0;
    if (accept && writes_rd)
      pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_instr_q <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      pending_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      pending_q  <= pending_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_instr_o   = ex_instr_q;
  assign ex_rs1_o     = ex_rs1_q;
  assign ex_rs2_o     = ex_rs2_q;
  assign ex_rd_addr_o = ex_rd_q;
  assign ex_rd_we_o   = ex_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a small register-file model plus a vector table
// and hand-written sequences for stalls, backpressure, flush and reset.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instrReady;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [31:0] rs1Data, rs2Data;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        exValid;
  logic        exReady;
  logic [31:0] exPc, exInstr, exRs1, exRs2;
  logic [4:0]  exRdAddr;
  logic        exRdWe;
  logic        flush;

  logic [31:0] rf [32];
  int          testsRun = 0;
  int          testsFailed = 0;

  operand_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_valid_i(instrValid),
    .instr_i      (instr),
    .pc_i         (pc),
    .instr_ready_o(instrReady),
    .rs1_addr_o   (rs1Addr),
    .rs2_addr_o   (rs2Addr),
    .rs1_data_i   (rs1Data),
    .rs2_data_i   (rs2Data),
    .wb_valid_i   (wbValid),
    .wb_addr_i    (wbAddr),
    .wb_data_i    (wbData),
    .ex_valid_o   (exValid),
    .ex_ready_i   (exReady),
    .ex_pc_o      (exPc),
    .ex_instr_o   (exInstr),
    .ex_rs1_o     (exRs1),
    .ex_rs2_o     (exRs2),
    .ex_rd_addr_o (exRdAddr),
    .ex_rd_we_o   (exRdWe),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write committed at the edge, x0 hardwired.
  assign rs1Data = rf[rs1Addr];
  assign rs2Data = rf[rs2Addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h100 + i;
    end else if (wbValid && wbAddr != 5'd0) begin
      rf[wbAddr] <= wbData;
    end
  end

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wbValid;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        expReady;
    logic        expExValid;
    logic [4:0]  expRd;
    logic        expWe;
    logic        chkRs1;
    logic [31:0] expRs1;
    logic        chkRs2;
    logic [31:0] expRs2;
    logic [31:0] expPending;
  } vector_t;

  vector_t vecs [8];

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic wv, input logic [4:0] wa, input logic [31:0] wd);
    instrValid = v;
    instr      = ins;
    pc         = p;
    wbValid    = wv;
    wbAddr     = wa;
    wbData     = wd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    exReady    = 1'b1;
    flush      = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

    //                valid instr         pc     wbV wbA   wbData        rdy exV rd  we  c1 rs1     c2 rs2      pending
    vecs[0] = '{1'b1, 32'h00500093, 32'h00, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,   32'h00000002};
    vecs[1] = '{1'b1, 32'h123452b7, 32'h04, 1'b1, 5'd1, 32'h11,       1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h00000020};
    vecs[2] = '{1'b1, 32'h00208333, 32'h08, 1'b1, 5'd5, 32'h12345000, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 32'h11, 1'b1, 32'h102, 32'h00000040};
    vecs[3] = '{1'b1, 32'h0061A023, 32'h0C, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h00000040};
    vecs[4] = '{1'b0, 32'h0,        32'h00, 1'b1, 5'd6, 32'h77,       1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h00000000};
    vecs[5] = '{1'b1, 32'h0061A023, 32'h0C, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h103,1'b1, 32'h77,  32'h00000000};
    vecs[6] = '{1'b1, 32'h00108013, 32'h10, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h11, 1'b0, 32'h0,   32'h00000000};
    vecs[7] = '{1'b1, 32'h00208063, 32'h14, 1'b1, 5'd0, 32'h99,       1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h11, 1'b1, 32'h102, 32'h00000000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_exValid", {31'b0, exValid}, 32'h0);
    checkOutput("rst_exPc", exPc, 32'h0);
    checkOutput("rst_exInstr", exInstr, 32'h0);
    checkOutput("rst_exRs1", exRs1, 32'h0);
    checkOutput("rst_exRs2", exRs2, 32'h0);
    checkOutput("rst_exRd", {27'b0, exRdAddr}, 32'h0);
    checkOutput("rst_exWe", {31'b0, exRdWe}, 32'h0);
    checkOutput("rst_ready", {31'b0, instrReady}, 32'h1);
    checkOutput("rst_pending", dut.pending_q, 32'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].pc,
                    vecs[i].wbValid, vecs[i].wbAddr, vecs[i].wbData);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), {31'b0, instrReady}, {31'b0, vecs[i].expReady});
      tick();
      checkOutput($sformatf("vec%0d_exValid", i), {31'b0, exValid}, {31'b0, vecs[i].expExValid});
      if (vecs[i].expExValid) begin
        checkOutput($sformatf("vec%0d_exPc", i), exPc, vecs[i].pc);
        checkOutput($sformatf("vec%0d_exInstr", i), exInstr, vecs[i].instr);
        checkOutput($sformatf("vec%0d_exRd", i), {27'b0, exRdAddr}, {27'b0, vecs[i].expRd});
        checkOutput($sformatf("vec%0d_exWe", i), {31'b0, exRdWe}, {31'b0, vecs[i].expWe});
        if (vecs[i].chkRs1) checkOutput($sformatf("vec%0d_exRs1", i), exRs1, vecs[i].expRs1);
        if (vecs[i].chkRs2) checkOutput($sformatf("vec%0d_exRs2", i), exRs2, vecs[i].expRs2);
      end
      checkOutput($sformatf("vec%0d_pending", i), dut.pending_q, vecs[i].expPending);
    end

    // RAW hazard on x1: ADDI x1,x0,5 then ADD x2,x1,x1.
    applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("raw_pending_x1", dut.pending_q, 32'h00000002);
    applyStimulus(1'b1, 32'h00108133, 32'h104, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("raw_stall_ready", {31'b0, instrReady}, 32'h0);
    tick();
    checkOutput("raw_drained", {31'b0, exValid}, 32'h0);
    applyStimulus(1'b1, 32'h00108133, 32'h104, 1'b1, 5'd1, 32'h5);
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    checkOutput("raw_wb_ready", {31'b0, instrReady}, 32'h1);
    tick();
    applyStimulus(1'b1, 32'h00108133, 32'h104, 1'b0, 5'd0, 32'h0);
`else
    checkOutput("raw_wb_ready", {31'b0, instrReady}, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h00108133, 32'h104, 1'b0, 5'd0, 32'h0);
    checkOutput("raw_still_empty", {31'b0, exValid}, 32'h0);
    #1;
    checkOutput("raw_late_ready", {31'b0, instrReady}, 32'h1);
    tick();
`endif
    checkOutput("raw_exValid", {31'b0, exValid}, 32'h1);
    checkOutput("raw_exRs1", exRs1, 32'h5);
    checkOutput("raw_exRs2", exRs2, 32'h5);
    checkOutput("raw_exRd", {27'b0, exRdAddr}, 32'd2);
    checkOutput("raw_pending", dut.pending_q, 32'h00000004);

    // Backpressure: execute stalls three cycles holding ADD x2.
    exReady = 1'b0;
    applyStimulus(1'b1, 32'h00700393, 32'h108, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready", c), {31'b0, instrReady}, 32'h0);
      tick();
      checkOutput($sformatf("bp%0d_exValid", c), {31'b0, exValid}, 32'h1);
      checkOutput($sformatf("bp%0d_exInstr", c), exInstr, 32'h00108133);
      checkOutput($sformatf("bp%0d_exPc", c), exPc, 32'h104);
      checkOutput($sformatf("bp%0d_exRs1", c), exRs1, 32'h5);
    end
    exReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, instrReady}, 32'h1);
    tick();
    checkOutput("bp_next_instr", exInstr, 32'h00700393);
    checkOutput("bp_next_rd", {27'b0, exRdAddr}, 32'd7);
    checkOutput("bp_pending", dut.pending_q, 32'h00000084);

    // Same-edge set and clear of x3 leaves the bit set.
    applyStimulus(1'b1, 32'h00100193, 32'h10C, 1'b1, 5'd3, 32'h33);
    #1;
    checkOutput("same_edge_ready", {31'b0, instrReady}, 32'h1);
    tick();
    checkOutput("same_edge_pending", dut.pending_q, 32'h0000008C);

    // Flush a held LW x4 while an ADDI x9 and a write to x0 are presented.
    applyStimulus(1'b1, 32'h0002A203, 32'h110, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("flush_lw_pending", dut.pending_q, 32'h0000009C);
    checkOutput("flush_lw_we", {31'b0, exRdWe}, 32'h1);
    checkOutput("flush_lw_rd", {27'b0, exRdAddr}, 32'd4);
    applyStimulus(1'b1, 32'h00100493, 32'h114, 1'b1, 5'd0, 32'hAB);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", {31'b0, instrReady}, 32'h0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("flush_exValid", {31'b0, exValid}, 32'h0);
    checkOutput("flush_pending", dut.pending_q, 32'h0000008C);
    checkOutput("flush_after_ready", {31'b0, instrReady}, 32'h1);

    // Reset while an entry is held under backpressure.
    exReady = 1'b0;
    applyStimulus(1'b1, 32'h00000513, 32'h118, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("midrst_held", {31'b0, exValid}, 32'h1);
    checkOutput("midrst_pending_pre", dut.pending_q, 32'h0000048C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_exValid", {31'b0, exValid}, 32'h0);
    checkOutput("midrst_exInstr", exInstr, 32'h0);
    checkOutput("midrst_pending", dut.pending_q, 32'h0);
    checkOutput("midrst_ready", {31'b0, instrReady}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
